// File: rtl/layer_backward.sv
// Backward pass of a matmul + shifted-ReLU layer: dx = M^T * (dy masked by y>0), one MAC per cycle.
// Define LAYER_BWD_SAT_EN to saturate each dx; otherwise dx wraps to its low bits.
module layer_backward #(
  parameter int bits        = 8,
  parameter int shift       = 0,
  parameter int row_size    = 10,
  parameter int column_size = 10
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [column_size-1:0][bits-1:0]           dy,
  input  logic [column_size-1:0][bits-1:0]           y,
  input  logic [row_size*column_size-1:0][bits-1:0]  M,
  output logic [row_size-1:0][bits-1:0]              dx,
  output logic                                       busy,
  output logic                                       done,
  output logic [1:0]                                 state_dbg
);

  localparam int ACC_W = 2*bits + $clog2(column_size) + 1;
  localparam int IW    = (row_size > 1) ? $clog2(row_size) : 1;
  localparam int JW    = (column_size > 1) ? $clog2(column_size) : 1;
  localparam int MW    = (row_size*column_size > 1) ? $clog2(row_size*column_size) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [JW-1:0]                 j_q, j_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [row_size-1:0][bits-1:0] dx_q, dx_d;

  logic [MW-1:0]                 m_idx;
  logic signed [bits-1:0]        g_sel;
  logic signed [bits-1:0]        m_sel;
  logic signed [2*bits-1:0]      prod;
  logic signed [ACC_W-1:0]       sum;
  logic [bits-1:0]               fin;

`ifdef LAYER_BWD_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2**(bits-1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(bits-1)));
  logic signed [ACC_W-1:0]       shifted;
`endif

  // Datapath: ReLU-derivative mask, product, running sum and finalize.
  always_comb begin
    m_idx = MW'(int'(i_q) * column_size + int'(j_q));
    g_sel = '0;
    if ($signed(y[j_q]) > 0) g_sel = $signed(dy[j_q]);
    m_sel = $signed(M[m_idx]);
    prod  = g_sel * m_sel;
    sum   = acc_q + ACC_W'(prod);
`ifdef LAYER_BWD_SAT_EN
    shifted = sum >>> shift;
    if (shifted > MAXV)      fin = MAXV[bits-1:0];
    else if (shifted < MINV) fin = MINV[bits-1:0];
    else                     fin = shifted[bits-1:0];
`else
    fin = bits'(sum >>> shift);
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    dx_d    = dx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (j_q == JW'(column_size - 1)) begin
          dx_d[i_q] = fin;
          acc_d     = '0;
          j_d       = '0;
          if (i_q == IW'(row_size - 1)) state_d = DONE;
          else                          i_d = i_q + 1'b1;
        end else begin
          acc_d = sum;
          j_d   = j_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      dx_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      dx_q    <= dx_d;
    end
  end

  assign dx        = dx_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule
